// File: rtl/apb4_mem_slave.sv
// APB4 completer around a word-addressed single-clock RAM.
// Configurable width, depth, base address and wait states; byte strobes and PSLVERR.
module apb4_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int WAIT_STATES = 0
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ADDR_WIDTH-1:0]     PADDR,
  input  logic [DATA_WIDTH-1:0]     PWDATA,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB,
  output logic [DATA_WIDTH-1:0]     PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(NB - 1);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wr_q, wr_d;
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0] strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic ready_q, ready_d;
  logic slverr_q, slverr_d;
  logic go_done;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] woff;
  logic dec_err;

  assign off  = PADDR - BASE_ADDR;
  assign woff = off >> LB;
  assign dec_err = (PADDR < BASE_ADDR)
                 | (woff >= ADDR_WIDTH'(DEPTH))
                 | ((off & AMASK) != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = '0;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    go_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d   = woff[IW-1:0];
          wr_d    = PWRITE;
          err_d   = dec_err;
          wdata_d = PWDATA;
          strb_d  = PSTRB;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          go_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered on entry to DONE, so they are valid for that cycle.
    if (go_done) begin
      state_d  = S_DONE;
      ready_d  = 1'b1;
      slverr_d = err_d;
      if (!wr_d && !err_d) rdata_d = mem[idx_d];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
    end
  end

  // Commit on the edge that ends DONE, unless the requester has dropped PSEL.
  always_ff @(posedge PCLK) begin
    if (!PRESET && state_q == S_DONE && PSEL && wr_q && !err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign PRDATA  = rdata_q;
  assign PREADY  = ready_q;
  assign PSLVERR = slverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed scoreboard bench for apb4_mem_slave.
// Two instances share one bus: WAIT_STATES=2 and WAIT_STATES=0.
module tb_apb4_mem_slave;

  logic        PCLK;
  logic        PRESET;
  logic        PSEL2, PSEL0;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA2, PRDATA0;
  logic        PREADY2, PREADY0;
  logic        PSLVERR2, PSLVERR0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    bit          rd_chk;
    string       tag;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mdl [logic [32:0]];
  int n_cmp = 0;
  int n_bad = 0;

  apb4_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
    .BASE_ADDR(32'h1000), .WAIT_STATES(2)
  ) u2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA2), .PREADY(PREADY2), .PSLVERR(PSLVERR2)
  );

  apb4_mem_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256),
    .BASE_ADDR(32'h1000), .WAIT_STATES(0)
  ) u0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(PSLVERR0)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge PCLK);
    PSEL2 = 1'b0;
    PSEL0 = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic xfer(input bit z, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input string tag);
    exp_t e;
    int n;
    logic [32:0] k;
    logic [31:0] w;
    k = {z, a};
    e.err = (a < 32'h1000) || (a >= 32'h1400) || (a[1:0] != 2'b00);
    e.rd = '0;
    if (!wr && !e.err && mdl.exists(k)) e.rd = mdl[k];
    e.lat = z ? 1 : 3;
    e.rd_chk = !wr;
    e.tag = tag;
    sb.push_back(e);
    if (wr && !e.err) begin
      w = mdl.exists(k) ? mdl[k] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      mdl[k] = w;
    end
    @(negedge PCLK);
    PSEL2 = !z;
    PSEL0 = z;
    PENABLE = 1'b0;
    PWRITE = wr;
    PADDR = a;
    PWDATA = d;
    PSTRB = s;
    @(negedge PCLK);
    PENABLE = 1'b1;
    n = 1;
    while (!(z ? PREADY0 : PREADY2) && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, ":lat"}, 32'(n), 32'(e.lat));
    chk({e.tag, ":err"}, {31'd0, z ? PSLVERR0 : PSLVERR2}, {31'd0, e.err});
    if (e.rd_chk) chk({e.tag, ":rd"}, z ? PRDATA0 : PRDATA2, e.rd);
  endtask

  initial begin
    PRESET = 1'b1;
    PSEL2 = 1'b0;
    PSEL0 = 1'b0;
    PENABLE = 1'b0;
    PWRITE = 1'b0;
    PADDR = '0;
    PWDATA = '0;
    PSTRB = '0;
    repeat (3) @(negedge PCLK);
    chk("rst_ready2", {31'd0, PREADY2}, 32'd0);
    chk("rst_err2", {31'd0, PSLVERR2}, 32'd0);
    chk("rst_rd2", PRDATA2, 32'd0);
    chk("rst_ready0", {31'd0, PREADY0}, 32'd0);
    chk("rst_rd0", PRDATA0, 32'd0);
    PRESET = 1'b0;
    idle();

    xfer(0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, "wr1004");
    idle();
    xfer(0, 0, 32'h1004, 32'h0, 4'h0, "rd1004");
    idle();
    @(negedge PCLK);
    chk("rd_clear", PRDATA2, 32'd0);

    xfer(0, 1, 32'h1008, 32'hFFFFFFFF, 4'hF, "wr1008a");
    xfer(0, 1, 32'h1008, 32'h11223344, 4'b0101, "wr1008b");
    xfer(0, 0, 32'h1008, 32'h0, 4'h0, "rd1008");
    xfer(0, 1, 32'h1008, 32'h99999999, 4'h0, "wr_nostrb");
    xfer(0, 0, 32'h1008, 32'h0, 4'hF, "rd1008b");
    idle();

    xfer(0, 1, 32'h1000, 32'hCAFEF00D, 4'hF, "wr1000");
    xfer(0, 0, 32'h1400, 32'h0, 4'h0, "rd_oor_hi");
    xfer(0, 0, 32'h0FFC, 32'h0, 4'h0, "rd_oor_lo");
    xfer(0, 1, 32'h1002, 32'h55555555, 4'hF, "wr_misal");
    xfer(0, 0, 32'h1000, 32'h0, 4'h0, "rd1000");
    xfer(0, 0, 32'h13FC, 32'h0, 4'h0, "rd_last");
    idle();

    @(negedge PCLK);
    PSEL2 = 1'b1;
    PENABLE = 1'b1;
    PWRITE = 1'b0;
    PADDR = 32'h1004;
    @(negedge PCLK);
    chk("pen_idle_a", {31'd0, PREADY2}, 32'd0);
    @(negedge PCLK);
    chk("pen_idle_b", {31'd0, PREADY2}, 32'd0);
    idle();

    for (int i = 0; i < 4; i++)
      xfer(0, 1, 32'h1020 + 32'(i * 4), 32'hA0B0C000 + 32'(i), 4'hF, "b2b_wr2");
    for (int i = 0; i < 4; i++)
      xfer(0, 0, 32'h1020 + 32'(i * 4), 32'h0, 4'h0, "b2b_rd2");
    idle();
    for (int i = 0; i < 4; i++)
      xfer(1, 1, 32'h1040 + 32'(i * 4), 32'h5EED0000 + 32'(i * 3), 4'hF, "b2b_wr0");
    for (int i = 0; i < 4; i++)
      xfer(1, 0, 32'h1040 + 32'(i * 4), 32'h0, 4'h0, "b2b_rd0");
    xfer(1, 0, 32'h1402, 32'h0, 4'h0, "rd0_err");
    idle();

    xfer(0, 1, 32'h1010, 32'hA5A5A5A5, 4'hF, "wr1010");
    idle();
    @(negedge PCLK);
    PSEL2 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b1;
    PADDR = 32'h1010;
    PWDATA = 32'h0;
    PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    chk("abort_wait", {31'd0, PREADY2}, 32'd0);
    @(negedge PCLK);
    PSEL2 = 1'b0;
    PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort_ready", {31'd0, PREADY2}, 32'd0);
    @(negedge PCLK);
    chk("abort_ready2", {31'd0, PREADY2}, 32'd0);
    xfer(0, 0, 32'h1010, 32'h0, 4'h0, "rd1010");
    idle();

    xfer(0, 1, 32'h1014, 32'h0, 4'hF, "wr1014");
    idle();
    @(negedge PCLK);
    PSEL2 = 1'b1;
    PENABLE = 1'b0;
    PWRITE = 1'b1;
    PADDR = 32'h1014;
    PWDATA = 32'h12345678;
    PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mrst_ready", {31'd0, PREADY2}, 32'd0);
    chk("mrst_err", {31'd0, PSLVERR2}, 32'd0);
    chk("mrst_rd", PRDATA2, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("mrst_idle_a", {31'd0, PREADY2}, 32'd0);
    @(negedge PCLK);
    chk("mrst_idle_b", {31'd0, PREADY2}, 32'd0);
    idle();
    xfer(0, 0, 32'h1014, 32'h0, 4'h0, "rd1014");
    xfer(0, 0, 32'h1004, 32'h0, 4'h0, "rd1004_post");
    idle();
    repeat (2) @(negedge PCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb4_mem_slave.md
Name: apb4_mem_slave

Overview:
Parametrised APB4 completer wrapping a single-clock word-addressed memory; successor to the fixed-width APB memory slave. Adds configurable data/address width, depth, base address and wait states, PSTRB byte-lane writes, and PSLVERR on out-of-range or misaligned access. Sits behind the APB bridge as a scratch/config RAM and is the DUT for the APB UVM bench.

Parameters:
ADDR_WIDTH, 32, PADDR width in bits.
DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32, 64.
DEPTH, 256, number of DATA_WIDTH words; power of two, >= 2.
BASE_ADDR, 'h0, byte address of word 0; aligned to DEPTH*DATA_WIDTH/8.
WAIT_STATES, 0, PREADY-low access cycles inserted before completion; 0..15.

Ports:
PCLK  input  1  clock; all logic on rising edge.
PRESET  input  1  synchronous reset, active-high.
PSEL  input  1  completer select.
PENABLE  input  1  access phase.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  ADDR_WIDTH  byte address.
PWDATA  input  DATA_WIDTH  write data.
PSTRB  input  DATA_WIDTH/8  write byte strobes.
PRDATA  output  DATA_WIDTH  read data.
PREADY  output  1  transfer completes this cycle.
PSLVERR  output  1  transfer error; valid only with PREADY.

Behaviour:
- One clock, PCLK; PRESET is synchronous and active-high. Reset: PREADY=0, PSLVERR=0, PRDATA=0, FSM=IDLE, wait counter=0. Memory contents not reset.
- All outputs registered; no combinational input->output path.
- FSM: IDLE, WAIT, DONE.
  - IDLE: on PSEL & !PENABLE (setup), latch PADDR, PWRITE, PWDATA, PSTRB and error flag; go to WAIT with cnt=WAIT_STATES-1 if WAIT_STATES>0, else to DONE.
  - WAIT: PREADY=0; decrement cnt; at cnt==0 go to DONE.
  - DONE: PREADY=1 for exactly one cycle; next state IDLE. This permits back-to-back transfers (next setup on the following cycle).
- Latency: PREADY rises in access cycle WAIT_STATES+1; the transfer takes WAIT_STATES+2 cycles including setup.
- Address decode: off = PADDR - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8).
  - err_range = PADDR < BASE_ADDR or idx >= DEPTH.
  - err_align = off low log2(DATA_WIDTH/8) bits nonzero.
  - err = err_range | err_align.
- Write: memory updates on the DONE-cycle edge, only for bytes with PSTRB[i]=1. A PSTRB of all zeros is a legal no-op with PSLVERR=0. An errored write leaves memory untouched.
- Read: PRDATA = mem[idx] captured entering DONE; PRDATA=0 when err. PRDATA returns to 0 in the cycle after DONE. PSTRB is ignored on reads.
- PSLVERR = err in DONE only; 0 in every other state.
- Abort: PSEL=0 in WAIT or DONE -> return to IDLE next edge, no memory write, PREADY/PSLVERR=0.
- PENABLE=1 while IDLE (no setup seen) is ignored and PREADY stays 0.
- PRESET asserted mid-transfer: FSM to IDLE, outputs to reset values, pending write discarded.
- Read-after-write to the same address on the next transfer returns the new data; no bypass hazard exists because transfers cannot overlap.

Test Plan:
- Config DATA_WIDTH=32, DEPTH=256, BASE_ADDR='h1000, WAIT_STATES=2. Write 'hDEADBEEF to 'h1004 with PSTRB='hF, then read 'h1004 -> PREADY high in the 3rd access cycle; PRDATA='hDEADBEEF; PSLVERR=0.
- Partial strobe: write 'hFFFFFFFF to 'h1008 with PSTRB='hF, then write 'h11223344 with PSTRB='b0101, then read -> 'hFF22FF44.
- Read 'h1400 (idx 256) and read 'h0FFC -> PSLVERR=1 with PREADY, PRDATA=0. Write 'h1002 (misaligned) -> PSLVERR=1; a following read of 'h1000 shows the prior value unchanged.
- Back-to-back: 4 writes with no idle cycles between transfers, then 4 reads -> each transfer takes exactly 4 cycles and all data matches. Repeat with WAIT_STATES=0 -> PREADY in the first access cycle, 2 cycles per transfer.
- Abort/reset: drop PSEL in the WAIT of a write to 'h1010 -> memory unchanged. Assert PRESET during WAIT -> next cycle PREADY=0, PSLVERR=0, PRDATA=0; the following transfer completes normally.
